// File: rtl/inst_prefetch_pkg.sv
// Shared definitions for the instruction prefetcher: FSM encodings, default
// FIFO depth and a saturating byte-counter helper.
// Imported by inst_prefetch and its storage sub-module.
package inst_prefetch_pkg;

  localparam int PF_DEPTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FETCH   = 2'd1,
    ST_DISCARD = 2'd2
  } pf_state_e;

  // 8-bit add that clamps at 255 instead of wrapping.
  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

endpackage

// File: rtl/inst_prefetch_fifo.sv
// prefetch_fifo: byte FIFO holding prefetched instruction bytes.
// Latency: a push in cycle M is visible on dout/empty in cycle M+1; dout is a
// storage read with no input-to-output path. Backpressure: push at full is dropped
// unless a pop happens the same cycle; pop at empty is ignored; flush wins over both.
// Ports: clk, reset (sync, active-high), push/din, pop/dout, flush, count, full, empty.
module prefetch_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8,
  parameter int AW    = $clog2(DEPTH),
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic          do_push, do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(DEPTH));
  assign count   = cnt_q;
  assign do_pop  = pop & ~empty;
  // A pop frees the slot this cycle, so a push at full is accepted alongside it.
  assign do_push = push & (~full | do_pop);
  // Hold the output at zero while empty so stale storage never leaks out.
  assign dout    = empty ? '0 : mem_q[rd_q];

  always_ff @(posedge clk) begin
    if (do_push && !flush && !reset) mem_q[wr_q] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/inst_prefetch.sv
// inst_prefetch: fetches instruction bytes ahead of the control unit into a small FIFO.
// Latency: byte acked in cycle M is at an empty FIFO head in cycle M+1; back-to-back
// requests with no idle cycle. Backpressure: stops requesting when the FIFO fills.
// Ports: clk, reset (sync, active-high); pc_load/pc_in redirect; mem_req/mem_addr/
// mem_ack/mem_data one-outstanding memory read; inst_pop/inst_data/inst_valid/head_pc
// head-of-queue to the control unit; flush_count only when PREFETCH_STATS_EN is defined.
module inst_prefetch
  import inst_prefetch_pkg::*;
#(
  parameter int DEPTH  = PF_DEPTH_DEFAULT,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_in,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [7:0]        mem_data,
  input  logic              inst_pop,
  output logic [7:0]        inst_data,
  output logic              inst_valid,
  output logic [ADDR_W-1:0] head_pc
`ifdef PREFETCH_STATS_EN
  ,
  output logic [7:0]        flush_count
`endif
);

  localparam int CW = $clog2(DEPTH + 1);

  pf_state_e         state_q, state_d;
  logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic [ADDR_W-1:0] head_pc_q, head_pc_d;

  logic          fifo_push, fifo_flush, fifo_full, fifo_empty, pop_eff;
  logic [CW-1:0] fifo_count;
  logic [CW:0]   cnt_after;

  // A redirect throws away whatever the head was, so it cancels a simultaneous pop.
  assign pop_eff   = inst_pop & ~fifo_empty & ~pc_load;
  assign cnt_after = {1'b0, fifo_count} + (CW+1)'(1) - (CW+1)'(pop_eff);

  prefetch_fifo #(.DEPTH(DEPTH), .W(8)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (pop_eff),
    .flush (fifo_flush),
    .din   (mem_data),
    .dout  (inst_data),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d      = state_q;
    fetch_addr_d = fetch_addr_q;
    req_addr_d   = req_addr_q;
    head_pc_d    = head_pc_q;
    fifo_push    = 1'b0;
    fifo_flush   = 1'b0;

    if (pc_load) begin
      fifo_flush   = 1'b1;
      fetch_addr_d = pc_in;
      head_pc_d    = pc_in;
    end else if (pop_eff) begin
      head_pc_d = head_pc_q + ADDR_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (!pc_load && !fifo_full) begin
          state_d    = ST_FETCH;
          req_addr_d = fetch_addr_q;
        end
      end
      ST_FETCH: begin
        if (pc_load) begin
          // Acked byte belongs to the old stream: drop it and restart at the target.
          if (mem_ack) begin
            req_addr_d = pc_in;
          end else begin
            state_d = ST_DISCARD;
          end
        end else if (mem_ack) begin
          fifo_push    = 1'b1;
          fetch_addr_d = fetch_addr_q + ADDR_W'(1);
          req_addr_d   = fetch_addr_q + ADDR_W'(1);
          if (cnt_after >= (CW+1)'(DEPTH)) state_d = ST_IDLE;
        end
      end
      ST_DISCARD: begin
        // The request on the bus must complete before a new address goes out;
        // the FIFO was flushed, so there is always room to restart at once.
        if (mem_ack) begin
          state_d    = ST_FETCH;
          req_addr_d = pc_load ? pc_in : fetch_addr_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      fetch_addr_q <= '0;
      req_addr_q   <= '0;
      head_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      req_addr_q   <= req_addr_d;
      head_pc_q    <= head_pc_d;
    end
  end

  assign mem_req    = (state_q != ST_IDLE);
  assign mem_addr   = req_addr_q;
  assign inst_valid = ~fifo_empty;
  assign head_pc    = head_pc_q;

`ifdef PREFETCH_STATS_EN
  logic [7:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    flush_cnt_d = flush_cnt_q;
    if (pc_load) flush_cnt_d = sat_add8(flush_cnt_d, 8'(fifo_count));
    if (state_q == ST_DISCARD && mem_ack) flush_cnt_d = sat_add8(flush_cnt_d, 8'd1);
  end

  always_ff @(posedge clk) begin
    if (reset) flush_cnt_q <= '0;
    else       flush_cnt_q <= flush_cnt_d;
  end

  assign flush_count = flush_cnt_q;
`else
  // Statistics disabled: no flushed-byte counter is built.
`endif

endmodule

// File: tb/tb_inst_prefetch.sv
module tb_inst_prefetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        pc_load;
  logic [15:0] pc_in;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_data;
  logic        inst_pop;
  logic [7:0]  inst_data;
  logic        inst_valid;
  logic [15:0] head_pc;
`ifdef PREFETCH_STATS_EN
  logic [7:0]  flush_count;
`endif

  int tests = 0;
  int fails = 0;

  inst_prefetch dut (
    .clk        (clk),
    .reset      (reset),
    .pc_load    (pc_load),
    .pc_in      (pc_in),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_data   (mem_data),
    .inst_pop   (inst_pop),
    .inst_data  (inst_data),
    .inst_valid (inst_valid),
    .head_pc    (head_pc)
`ifdef PREFETCH_STATS_EN
    ,
    .flush_count(flush_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic head(input string tag, input logic v, input logic [7:0] d, input logic [15:0] pc);
    check({tag, "_valid"}, 32'(inst_valid), 32'(v));
    if (v) check({tag, "_data"}, 32'(inst_data), 32'(d));
    check({tag, "_pc"}, 32'(head_pc), 32'(pc));
  endtask

  // Wait (bounded) for a request, check its address and that it holds, then ack it.
  task automatic ack_byte(input logic [7:0] d, input logic [15:0] a, input logic pop);
    int n;
    n = 0;
    while (mem_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("req_seen", 32'(mem_req), 32'd1);
    check("req_addr", 32'(mem_addr), 32'(a));
    tick();
    check("req_hold", 32'(mem_addr), 32'(a));
    mem_ack  = 1'b1;
    mem_data = d;
    inst_pop = pop;
    tick();
    mem_ack  = 1'b0;
    inst_pop = 1'b0;
  endtask

  task automatic pop_check(input logic [7:0] d, input logic [15:0] pc);
    head("pop_head", 1'b1, d, pc);
    inst_pop = 1'b1;
    tick();
    inst_pop = 1'b0;
  endtask

  initial begin
    reset = 1'b1; pc_load = 1'b0; pc_in = '0; mem_ack = 1'b0;
    mem_data = '0; inst_pop = 1'b0;
    tick(); tick();
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_data", 32'(inst_data), 32'd0);
    head("rst", 1'b0, 8'h00, 16'h0000);
`ifdef PREFETCH_STATS_EN
    check("rst_flush_cnt", 32'(flush_count), 32'd0);
`endif

    // Ack in the first cycle after reset must be ignored.
    reset = 1'b0; mem_ack = 1'b1; mem_data = 8'hEE;
    tick();
    mem_ack = 1'b0;
    check("post_rst_req", 32'(mem_req), 32'd1);
    check("post_rst_addr", 32'(mem_addr), 32'd0);
    check("post_rst_valid", 32'(inst_valid), 32'd0);

    // Fill the FIFO.
    ack_byte(8'h11, 16'h0000, 1'b0);
    head("first_byte", 1'b1, 8'h11, 16'h0000);
    ack_byte(8'h22, 16'h0001, 1'b0);
    ack_byte(8'h33, 16'h0002, 1'b0);
    ack_byte(8'h44, 16'h0003, 1'b0);
    check("full_req", 32'(mem_req), 32'd0);
    tick(); tick();
    check("full_req_idle", 32'(mem_req), 32'd0);
    head("full_head", 1'b1, 8'h11, 16'h0000);

    // One pop frees one slot: exactly one new request at 4.
    inst_pop = 1'b1; tick(); inst_pop = 1'b0;
    head("pop1", 1'b1, 8'h22, 16'h0001);
    ack_byte(8'h55, 16'h0004, 1'b0);
    check("refull_req", 32'(mem_req), 32'd0);

    // Ack and pop together one below full: count stays at 3, so one more ack fills.
    inst_pop = 1'b1; tick(); inst_pop = 1'b0;
    head("pop2", 1'b1, 8'h33, 16'h0002);
    ack_byte(8'h66, 16'h0005, 1'b1);
    head("ackpop_head", 1'b1, 8'h44, 16'h0003);
    check("ackpop_req", 32'(mem_req), 32'd1);
    ack_byte(8'h77, 16'h0006, 1'b0);
    check("ackpop_full_req", 32'(mem_req), 32'd0);

    // Drain in order.
    pop_check(8'h44, 16'h0003);
    pop_check(8'h55, 16'h0004);
    pop_check(8'h66, 16'h0005);
    pop_check(8'h77, 16'h0006);
    head("drained", 1'b0, 8'h00, 16'h0007);

    // Pop on empty is ignored.
    inst_pop = 1'b1; tick(); inst_pop = 1'b0;
    head("pop_empty", 1'b0, 8'h00, 16'h0007);

    // Ack and pop at empty: push lands, pop ignored.
    ack_byte(8'h88, 16'h0007, 1'b1);
    head("ackpop_empty", 1'b1, 8'h88, 16'h0007);

    // Redirect while a request is pending, with a simultaneous pop (outranked).
    check("pend_addr", 32'(mem_addr), 32'h0008);
    pc_load = 1'b1; pc_in = 16'h0100; inst_pop = 1'b1;
    tick();
    pc_load = 1'b0; inst_pop = 1'b0;
    head("redir", 1'b0, 8'h00, 16'h0100);
    check("discard_req", 32'(mem_req), 32'd1);
    check("discard_addr", 32'(mem_addr), 32'h0008);
    tick(); tick();
    check("discard_hold", 32'(mem_addr), 32'h0008);
    mem_ack = 1'b1; mem_data = 8'h99;
    tick();
    mem_ack = 1'b0;
    check("after_drop_valid", 32'(inst_valid), 32'd0);
    check("after_drop_addr", 32'(mem_addr), 32'h0100);
`ifdef PREFETCH_STATS_EN
    check("flush_cnt_discard", 32'(flush_count), 32'd2);
`endif
    ack_byte(8'hA1, 16'h0100, 1'b0);
    head("target_byte", 1'b1, 8'hA1, 16'h0100);

    // Redirect coinciding with an ack: byte dropped, no discard cycle.
    pc_load = 1'b1; pc_in = 16'hFFFE; mem_ack = 1'b1; mem_data = 8'hBB;
    tick();
    pc_load = 1'b0; mem_ack = 1'b0;
    head("redir_ack", 1'b0, 8'h00, 16'hFFFE);
    check("redir_ack_req", 32'(mem_req), 32'd1);
    check("redir_ack_addr", 32'(mem_addr), 32'hFFFE);
`ifdef PREFETCH_STATS_EN
    check("flush_cnt_ack", 32'(flush_count), 32'd3);
`endif

    // Address wrap.
    ack_byte(8'h01, 16'hFFFE, 1'b0);
    ack_byte(8'h02, 16'hFFFF, 1'b0);
    ack_byte(8'h03, 16'h0000, 1'b0);
    pop_check(8'h01, 16'hFFFE);
    pop_check(8'h02, 16'hFFFF);
    pop_check(8'h03, 16'h0000);
    head("wrap_drained", 1'b0, 8'h00, 16'h0001);
    check("wrap_pend_addr", 32'(mem_addr), 32'h0001);

    // Reset mid-request, with an ack arriving during reset.
    reset = 1'b1; mem_ack = 1'b1; mem_data = 8'h5A;
    tick();
    check("midrst_req", 32'(mem_req), 32'd0);
    check("midrst_addr", 32'(mem_addr), 32'd0);
    head("midrst", 1'b0, 8'h00, 16'h0000);
`ifdef PREFETCH_STATS_EN
    check("midrst_flush_cnt", 32'(flush_count), 32'd0);
`endif
    reset = 1'b0; mem_ack = 1'b0;
    tick();
    check("rerun_req", 32'(mem_req), 32'd1);
    check("rerun_addr", 32'(mem_addr), 32'd0);
    check("rerun_valid", 32'(inst_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
